// File: rtl/vga_frame_scanner_pkg.sv
// Shared colour encodings, default 640x480@60 frame totals and pixel-term types
// for the VGA frame scanner.
`ifndef VGA_FRAME_SCANNER_DEFS
`define VGA_FRAME_SCANNER_DEFS
`define H_TOTAL 800
`define V_TOTAL 525
`endif

package vga_frame_scanner_pkg;

    localparam logic [2:0] COLOR_BLACK   = 3'b000;
    localparam logic [2:0] COLOR_BLUE    = 3'b001;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_CYAN    = 3'b011;
    localparam logic [2:0] COLOR_RED     = 3'b100;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;
    localparam logic [2:0] COLOR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOR_WHITE   = 3'b111;

    localparam int H_TOTAL_DEFAULT = `H_TOTAL;
    localparam int V_TOTAL_DEFAULT = `V_TOTAL;
    localparam int WIN_SIZE        = 256;

    typedef struct packed {
        logic in_win;
        logic visible;
        logic hsync_n;
        logic vsync_n;
    } pix_term_t;

    function automatic logic in_range(input logic [9:0] val,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_frame_scanner_timing.sv
// Pixel-enable divider plus horizontal/vertical scan counters and the raw
// visible / sync terms for the current counter position.
module vga_timing_counter
    import vga_frame_scanner_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    output logic       pix_en_o,
    output logic [9:0] hcount_o,
    output logic [9:0] vcount_o,
    output logic [9:0] hcount_nxt_o,
    output logic [9:0] vcount_nxt_o,
    output logic       visible_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       pix_en_q, pix_en_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;

    always_comb begin
        pix_en_d = ~pix_en_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pix_en_q <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            pix_en_q <= pix_en_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign pix_en_o     = pix_en_q;
    assign hcount_o     = hcount_q;
    assign vcount_o     = vcount_q;
    assign hcount_nxt_o = hcount_d;
    assign vcount_nxt_o = vcount_d;
    assign visible_o    = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    assign hsync_n_o    = ~in_range(hcount_q, HS_FIRST, HS_LAST);
    assign vsync_n_o    = ~in_range(vcount_q, VS_FIRST, VS_LAST);

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA back end: scans a centred 256x256 video RAM window, paints the border,
// and drives RGB and syncs two Clocks behind the scan counters.
module vga_frame_scanner
    import vga_frame_scanner_pkg::*;
#(
    parameter int         H_VISIBLE    = 640,
    parameter int         H_FRONT      = 16,
    parameter int         H_SYNC       = 96,
    parameter int         H_BACK       = 48,
    parameter int         V_VISIBLE    = 480,
    parameter int         V_FRONT      = 10,
    parameter int         V_SYNC       = 2,
    parameter int         V_BACK       = 33,
    parameter int         X_OFFSET     = 192,
    parameter int         Y_OFFSET     = 112,
    parameter logic [2:0] BORDER_COLOR = COLOR_BLACK
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oRamAddress,
    input  logic [2:0]  iRamData,
    output logic        oVGA_R,
    output logic        oVGA_G,
    output logic        oVGA_B,
    output logic        oHSync,
    output logic        oVSync,
    output logic        oFrameStart
);

    localparam logic [9:0] X_FIRST = 10'(X_OFFSET);
    localparam logic [9:0] X_LAST  = 10'(X_OFFSET + WIN_SIZE - 1);
    localparam logic [9:0] Y_FIRST = 10'(Y_OFFSET);
    localparam logic [9:0] Y_LAST  = 10'(Y_OFFSET + WIN_SIZE - 1);

    logic       pix_en, visible, hsync_n, vsync_n;
    logic [9:0] hcount, vcount, hcount_nxt, vcount_nxt;
    logic       nxt_in_win, cur_in_win;

    logic [15:0] addr_q, addr_d;
    pix_term_t   term_q, term_d;
    logic [2:0]  data_q, data_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_q, frame_d;

    vga_timing_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk_i        (Clock),
        .rst_n_i      (Reset),
        .pix_en_o     (pix_en),
        .hcount_o     (hcount),
        .vcount_o     (vcount),
        .hcount_nxt_o (hcount_nxt),
        .vcount_nxt_o (vcount_nxt),
        .visible_o    (visible),
        .hsync_n_o    (hsync_n),
        .vsync_n_o    (vsync_n)
    );

    // The address is issued from the next counter values so the RAM data
    // lands on the following (pix_en=0) Clock for the pixel now being scanned.
    assign nxt_in_win = in_range(hcount_nxt, X_FIRST, X_LAST) && in_range(vcount_nxt, Y_FIRST, Y_LAST);
    assign cur_in_win = in_range(hcount, X_FIRST, X_LAST) && in_range(vcount, Y_FIRST, Y_LAST);

    always_comb begin
        addr_d  = addr_q;
        term_d  = term_q;
        data_d  = data_q;
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        frame_d = !pix_en && (hcount == '0) && (vcount == '0);
        if (pix_en) begin
            if (nxt_in_win) begin
                addr_d = {8'(vcount_nxt - Y_FIRST), 8'(hcount_nxt - X_FIRST)};
            end
            if (!term_q.visible) begin
                rgb_d = COLOR_BLACK;
            end else begin
                rgb_d = term_q.in_win ? data_q : BORDER_COLOR;
            end
            hsync_d = term_q.hsync_n;
            vsync_d = term_q.vsync_n;
        end else begin
            term_d.in_win  = cur_in_win;
            term_d.visible = visible;
            term_d.hsync_n = hsync_n;
            term_d.vsync_n = vsync_n;
            data_d         = iRamData;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            addr_q  <= '0;
            term_q  <= '{in_win: 1'b0, visible: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};
            data_q  <= '0;
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            term_q  <= term_d;
            data_q  <= data_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            frame_q <= frame_d;
        end
    end

    assign oRamAddress = addr_q;
    assign oVGA_R      = rgb_q[2];
    assign oVGA_G      = rgb_q[1];
    assign oVGA_B      = rgb_q[0];
    assign oHSync      = hsync_q;
    assign oVSync      = vsync_q;
    assign oFrameStart = frame_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner on a shrunk timing set so whole frames fit in a
// short run; pixel scoreboard plus a table of hand-computed pixels.
module tb_vga_frame_scanner;
    import vga_frame_scanner_pkg::*;

    localparam int HV = 280, HF = 8, HS = 16, HB = 8;
    localparam int VV = 20,  VF = 2, VS = 2,  VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int X_OFF = 16, Y_OFF = 4;
    localparam logic [2:0] BORDER = COLOR_BLUE;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } pins_t;

    typedef struct {
        int          h;
        int          v;
        logic        chk_addr;
        logic [15:0] addr;
        logic [2:0]  rgb;
        logic        hs;
        logic        vs;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        rst_b   = 1'b0;
    logic [15:0] ram_addr;
    logic [2:0]  ram_data;
    logic [7:0]  ram_x;
    logic        vga_r, vga_g, vga_b, hsync, vsync, frame_start;

    logic rst_s = 1'b0;
    int   n = 0;
    int   checks = 0;
    int   failures = 0;

    pins_t       sbq[$];
    logic [15:0] addr_m;
    vec_t        tbl[16];

    vga_frame_scanner #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .X_OFFSET (X_OFF), .Y_OFFSET (Y_OFF), .BORDER_COLOR (BORDER)
    ) u_dut (
        .Clock       (clk_sys),
        .Reset       (rst_b),
        .oRamAddress (ram_addr),
        .iRamData    (ram_data),
        .oVGA_R      (vga_r),
        .oVGA_G      (vga_g),
        .oVGA_B      (vga_b),
        .oHSync      (hsync),
        .oVSync      (vsync),
        .oFrameStart (frame_start)
    );

    // Video RAM model: colour at (col,row) is (col^row)&7.
    assign ram_x    = ram_addr[7:0] ^ ram_addr[15:8];
    assign ram_data = ram_x[2:0];

    always #10 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        rst_s <= rst_b;
        n     <= rst_b ? n + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (n=%0d)", name, got, want, n);
        end
    endtask

    function automatic logic tb_in_win(input int h, input int v);
        return (h >= X_OFF) && (h <= X_OFF + 255) && (v >= Y_OFF) && (v <= Y_OFF + 255);
    endfunction

    function automatic pins_t exp_pins(input int h, input int v);
        pins_t p;
        if (h >= HV || v >= VV)  p.rgb = 3'b000;
        else if (tb_in_win(h, v)) p.rgb = 3'(((h - X_OFF) ^ (v - Y_OFF)) & 7);
        else                      p.rgb = BORDER;
        p.hs = !((h >= HV + HF) && (h < HV + HF + HS));
        p.vs = !((v >= VV + VF) && (v < VV + VF + VS));
        return p;
    endfunction

    function automatic pins_t got_pins();
        pins_t p;
        p.rgb = {vga_r, vga_g, vga_b};
        p.hs  = hsync;
        p.vs  = vsync;
        return p;
    endfunction

    function automatic logic pick(input int sel);
        if (sel == 0) return hsync;
        if (sel == 1) return vsync;
        return !frame_start;
    endfunction

    // Scoreboard: pixel k's counters are current after edge 2k+1 (push),
    // its pins are valid after edge 2k+2 (pop and compare).
    always @(negedge clk_sys) begin
        pins_t want;
        int k, h, v;
        if (!rst_s) begin
            sbq.delete();
            addr_m = '0;
            chk("reset_pins", 32'(got_pins()), 32'(pins_t'{3'b000, 1'b1, 1'b1}));
            chk("reset_addr", 32'(ram_addr), 32'h0);
            chk("reset_frame", 32'(frame_start), 32'h0);
        end else if (n % 2 == 1) begin
            k = (n - 1) / 2;
            h = k % HT;
            v = (k / HT) % VT;
            sbq.push_back(exp_pins(h, v));
            if (tb_in_win(h, v)) addr_m = {8'(v - Y_OFF), 8'(h - X_OFF)};
            chk("sb_addr", 32'(ram_addr), 32'(addr_m));
            chk("sb_frame_odd", 32'(frame_start), 32'((k % (HT * VT)) == 0));
        end else if (n > 0) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty got=none want=pixel (n=%0d)", n);
            end else begin
                want = sbq.pop_front();
                chk("sb_pins", 32'(got_pins()), 32'(want));
            end
            chk("sb_frame_even", 32'(frame_start), 32'h0);
        end
    end

    task automatic wait_n(input int target, input string tag);
        int guard = 0;
        while (n < target && guard < 40000) begin
            @(negedge clk_sys);
            guard++;
        end
        checks++;
        if (n < target) begin
            failures++;
            $display("FAIL %s_timeout got=%0d want=%0d", tag, n, target);
        end
    endtask

    task automatic measure_pulse(input int sel, input int exp_fall, input int exp_width, input string tag);
        int   guard = 0;
        int   t_fall = -1;
        int   t_rise = -1;
        logic prev, cur;
        prev = pick(sel);
        while (t_rise < 0 && guard < 40000) begin
            @(negedge clk_sys);
            guard++;
            cur = pick(sel);
            if (prev && !cur && t_fall < 0)        t_fall = n;
            else if (!prev && cur && t_fall >= 0)  t_rise = n;
            prev = cur;
        end
        chk({tag, "_fall"}, t_fall, exp_fall);
        chk({tag, "_width"}, t_rise - t_fall, exp_width);
    endtask

    initial begin
        #(64'd1600000);
        $display("FAIL watchdog got=running want=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,   0,  1'b0, 16'h0000, 3'b001, 1'b1, 1'b1};
        tbl[1]  = '{16,  4,  1'b1, 16'h0000, 3'b000, 1'b1, 1'b1};
        tbl[2]  = '{17,  4,  1'b1, 16'h0001, 3'b001, 1'b1, 1'b1};
        tbl[3]  = '{271, 5,  1'b1, 16'h01FF, 3'b110, 1'b1, 1'b1};
        tbl[4]  = '{272, 5,  1'b1, 16'h01FF, 3'b001, 1'b1, 1'b1};
        tbl[5]  = '{23,  6,  1'b1, 16'h0207, 3'b101, 1'b1, 1'b1};
        tbl[6]  = '{10,  7,  1'b0, 16'h0000, 3'b001, 1'b1, 1'b1};
        tbl[7]  = '{287, 7,  1'b0, 16'h0000, 3'b000, 1'b1, 1'b1};
        tbl[8]  = '{288, 7,  1'b0, 16'h0000, 3'b000, 1'b0, 1'b1};
        tbl[9]  = '{303, 7,  1'b0, 16'h0000, 3'b000, 1'b0, 1'b1};
        tbl[10] = '{304, 7,  1'b0, 16'h0000, 3'b000, 1'b1, 1'b1};
        tbl[11] = '{20,  9,  1'b1, 16'h0504, 3'b001, 1'b1, 1'b1};
        tbl[12] = '{100, 21, 1'b1, 16'h1154, 3'b000, 1'b1, 1'b1};
        tbl[13] = '{5,   22, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b0};
        tbl[14] = '{300, 22, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b0};
        tbl[15] = '{5,   24, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b1};

        rst_b = 1'b0;
        repeat (5) @(negedge clk_sys);
        rst_b = 1'b1;

        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    int k;
                    pins_t want;
                    k = tbl[i].v * HT + tbl[i].h;
                    wait_n(2 * k + 1, "tbl_addr_wait");
                    if (tbl[i].chk_addr) chk($sformatf("tbl%0d_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
                    wait_n(2 * k + 2, "tbl_pin_wait");
                    want.rgb = tbl[i].rgb;
                    want.hs  = tbl[i].hs;
                    want.vs  = tbl[i].vs;
                    chk($sformatf("tbl%0d_pins", i), 32'(got_pins()), 32'(want));
                end
            end
            begin
                measure_pulse(0, 2 * (HV + HF) + 2, 2 * HS, "hsync_line0");
                measure_pulse(0, 2 * (HV + HF) + 2 + 2 * HT, 2 * HS, "hsync_line1");
            end
            begin
                measure_pulse(1, 2 * (VV + VF) * HT + 2, 2 * VS * HT, "vsync");
            end
            begin
                measure_pulse(2, 1, 1, "frame0");
                measure_pulse(2, 1 + 2 * HT * VT, 1, "frame1");
            end
        join

        // Mid-frame reset while the second frame is inside an hsync pulse.
        wait_n(2 * HT * VT + 2 * (10 * HT + 295) + 2, "pre_reset");
        chk("hsync_before_reset", 32'(hsync), 32'h0);
        rst_b = 1'b0;
        @(negedge clk_sys);
        chk("hsync_after_reset", 32'(hsync), 32'h1);
        chk("vsync_after_reset", 32'(vsync), 32'h1);
        chk("addr_after_reset", 32'(ram_addr), 32'h0);
        rst_b = 1'b1;
        measure_pulse(0, 2 * (HV + HF) + 2, 2 * HS, "hsync_restart");
        wait_n(1300, "tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
